// File: rtl/l1_cache_if.sv
// CPU-side and bus-side ports of the L1 cache, bundled so the cache and its
// environment connect through one interface instance.
interface l1_cache_if;
  // Both sides use one-cycle request pulses (rd/we, mem_rd/mem_we) answered by
  // a completion strobe (ready, mem_ready); data is valid only while the
  // strobe is 1, and a new request is issued only after the previous strobe.
  logic [31:0] a;
  logic [31:0] d;
  logic        we;
  logic        rd;
  logic [31:0] spo;
  logic        ready;
  logic [31:0] mem_a;
  logic [31:0] mem_d;
  logic        mem_we;
  logic        mem_rd;
  logic [31:0] mem_spo;
  logic        mem_ready;

  modport slave (
    input  a, d, we, rd, mem_spo, mem_ready,
    output spo, ready, mem_a, mem_d, mem_we, mem_rd
  );

  modport master (
    output a, d, we, rd, mem_spo, mem_ready,
    input  spo, ready, mem_a, mem_d, mem_we, mem_rd
  );
endinterface

// File: rtl/l1_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 cache with 4-word lines.
// Cacheable read hits complete combinationally; everything else uses the bus.
module l1_cache #(
  parameter int unsigned LINES     = 256,
  parameter logic [3:0]  CACHED_HI = 4'h2
) (
  input  logic       clk,
  input  logic       rst,
  l1_cache_if.slave  bus,
  output logic [2:0] state_o
);
  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 28 - IW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_BYP_REQ,
    S_BYP_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_RESP
  } state_e;

  state_e          state_q;
  logic [29:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [1:0]      cnt_q;
  logic [1:0]      cnt_d;
  logic [31:0]     resp_q;
  logic [31:0]     mem_a_q;
  logic [31:0]     mem_d_q;
  logic            mem_rd_q;
  logic            mem_we_q;

  logic [31:0]     data_q [LINES*4];
  logic [TW-1:0]   tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  logic [IW-1:0]   req_idx;
  logic [TW-1:0]   req_tag;
  logic [1:0]      req_off;
  logic [IW-1:0]   lat_idx;
  logic [TW-1:0]   lat_tag;
  logic            req_cached;
  logic            req_hit;
  logic            hit_rd;
  logic [31:0]     hit_word;
  logic            unused_addr_bits;

  assign req_idx  = bus.a[IW+3:4];
  assign req_tag  = bus.a[31:IW+4];
  assign req_off  = bus.a[3:2];
  assign lat_idx  = addr_q[IW+1:2];
  assign lat_tag  = addr_q[29:IW+2];
  assign cnt_d    = cnt_q + 2'd1;
  assign unused_addr_bits = ^bus.a[1:0];

  assign req_cached = (bus.a[31:28] == CACHED_HI);
  assign req_hit    = req_cached && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign hit_word   = data_q[{req_idx, req_off}];
  // A simultaneous write takes priority, so only a lone read can hit.
  assign hit_rd     = (state_q == S_IDLE) && bus.rd && !bus.we && req_hit;

  assign bus.ready  = hit_rd || (state_q == S_RESP);
  assign bus.spo    = hit_rd ? hit_word : ((state_q == S_RESP) ? resp_q : 32'h0);
  assign bus.mem_a  = mem_a_q;
  assign bus.mem_d  = mem_d_q;
  assign bus.mem_rd = mem_rd_q;
  assign bus.mem_we = mem_we_q;
  assign state_o    = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      valid_q  <= '0;
      cnt_q    <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      resp_q   <= '0;
      mem_a_q  <= '0;
      mem_d_q  <= '0;
      mem_rd_q <= 1'b0;
      mem_we_q <= 1'b0;
    end else begin
      mem_rd_q <= 1'b0;
      mem_we_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.we) begin
            addr_q   <= bus.a[31:2];
            wdata_q  <= bus.d;
            if (req_hit) data_q[{req_idx, req_off}] <= bus.d;
            mem_a_q  <= {bus.a[31:2], 2'b00};
            mem_d_q  <= bus.d;
            mem_we_q <= 1'b1;
            state_q  <= S_WR_REQ;
          end else if (bus.rd && !req_hit) begin
            addr_q   <= bus.a[31:2];
            mem_rd_q <= 1'b1;
            if (req_cached) begin
              cnt_q   <= 2'd0;
              mem_a_q <= {bus.a[31:4], 4'b0000};
              state_q <= S_FILL_REQ;
            end else begin
              mem_a_q <= {bus.a[31:2], 2'b00};
              state_q <= S_BYP_REQ;
            end
          end
        end
        S_FILL_REQ, S_FILL_WAIT: begin
          if (bus.mem_ready) begin
            data_q[{lat_idx, cnt_q}] <= bus.mem_spo;
            if (cnt_q == addr_q[1:0]) resp_q <= bus.mem_spo;
            // The line becomes valid only with its last word, so an aborted
            // fill never leaves a partially valid line behind.
            if (cnt_q == 2'd3) begin
              tag_q[lat_idx]   <= lat_tag;
              valid_q[lat_idx] <= 1'b1;
              state_q          <= S_RESP;
            end else begin
              cnt_q    <= cnt_d;
              mem_a_q  <= {addr_q[29:2], cnt_d, 2'b00};
              mem_rd_q <= 1'b1;
              state_q  <= S_FILL_REQ;
            end
          end else begin
            state_q <= S_FILL_WAIT;
          end
        end
        S_BYP_REQ, S_BYP_WAIT: begin
          if (bus.mem_ready) begin
            resp_q  <= bus.mem_spo;
            state_q <= S_RESP;
          end else begin
            state_q <= S_BYP_WAIT;
          end
        end
        S_WR_REQ, S_WR_WAIT: begin
          if (bus.mem_ready) begin
            resp_q  <= 32'h0;
            state_q <= S_RESP;
          end else begin
            state_q <= S_WR_WAIT;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_l1_cache.sv
// Self-checking bench for l1_cache: a bus responder with a sparse memory and
// a high-level residency model predict data, latency and bus traffic.
module tb_l1_cache;
  localparam int LINES = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l1_cache_if bus_if ();
  logic [2:0] unused_state;

  l1_cache #(.LINES(LINES), .CACHED_HI(4'h2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .state_o (unused_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int bus_delay = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [31:0] wmem [logic [31:0]];
  int          res_tag [int];

  function automatic logic [31:0] mem_val(input logic [31:0] addr);
    logic [31:0] w;
    w = {addr[31:2], 2'b00};
    if (wmem.exists(w)) return wmem[w];
    return w ^ 32'hA5A5A5A5;
  endfunction

  function automatic bit is_cached(input logic [31:0] addr);
    return addr[31:28] == 4'h2;
  endfunction

  function automatic int idx_of(input logic [31:0] addr);
    return int'((addr >> 4) % LINES);
  endfunction

  function automatic int tag_of(input logic [31:0] addr);
    return int'(addr / (LINES * 16));
  endfunction

  function automatic bit model_hit(input logic [31:0] addr);
    return is_cached(addr) && res_tag.exists(idx_of(addr)) && res_tag[idx_of(addr)] == tag_of(addr);
  endfunction

  function automatic int exp_lat(input bit is_wr, input logic [31:0] addr, input int dly);
    if (is_wr || !is_cached(addr)) return 2 + dly;
    if (model_hit(addr)) return 0;
    return 1 + 4 * (1 + dly);
  endfunction

  // ---------------- bus responder ----------------
  bit          pending = 0;
  bit          pend_wr = 0;
  logic [31:0] pend_d;
  int          wait_left = 0;

  always @(negedge clk) begin
    if (rst) begin
      pending = 0;
      bus_if.mem_ready = 1'b0;
      bus_if.mem_spo   = 32'h0;
    end else begin
      if (bus_if.mem_rd || bus_if.mem_we) begin
        pending   = 1;
        pend_wr   = bus_if.mem_we;
        pend_d    = bus_if.mem_d;
        wait_left = bus_delay;
      end
      if (pending && wait_left == 0) begin
        bus_if.mem_ready = 1'b1;
        if (pend_wr) begin
          wmem[{bus_if.mem_a[31:2], 2'b00}] = pend_d;
          bus_if.mem_spo = $urandom;
        end else begin
          bus_if.mem_spo = mem_val(bus_if.mem_a);
        end
        pending = 0;
      end else begin
        bus_if.mem_ready = 1'b0;
        bus_if.mem_spo   = $urandom;
        if (pending) wait_left--;
      end
    end
  end

  // ---------------- bus monitor ----------------
  logic [31:0] rd_addr_q[$];
  int          rd_cyc_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.mem_rd) begin
        rd_addr_q.push_back(bus_if.mem_a);
        rd_cyc_q.push_back(cyc);
      end
      if (bus_if.mem_we) begin
        wr_addr_q.push_back(bus_if.mem_a);
        wr_data_q.push_back(bus_if.mem_d);
        wr_cyc_q.push_back(cyc);
      end
      if (bus_if.mem_rd || bus_if.mem_we) begin
        n_cmp++;
        if ((bus_if.mem_rd && bus_if.mem_we) || bus_if.mem_a[1:0] != 2'b00) begin
          n_bad++;
          $display("FAIL bus_pulse: rd=%b we=%b a=%h, required single pulse with aligned address",
                   bus_if.mem_rd, bus_if.mem_we, bus_if.mem_a);
        end
      end
    end
  end

  task automatic clear_log();
    rd_addr_q.delete(); rd_cyc_q.delete();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    exp_q.delete();
  endtask

  // ---------------- CPU driver ----------------
  task automatic cpu_req(input bit is_wr, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rdata, output int lat, output int t0);
    rdata = 'x;
    lat   = -1;
    @(negedge clk);
    bus_if.a  = addr;
    bus_if.d  = wd;
    bus_if.we = is_wr;
    bus_if.rd = !is_wr;
    t0 = cyc;
    #1;
    if (bus_if.ready) begin lat = 0; rdata = bus_if.spo; end
    @(posedge clk); #1;
    bus_if.we = 1'b0;
    bus_if.rd = 1'b0;
    for (int i = 1; i <= 60 && lat < 0; i++) begin
      @(negedge clk); #1;
      if (bus_if.ready) begin lat = i; rdata = bus_if.spo; end
    end
  endtask

  task automatic hold_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); @(negedge clk); @(posedge clk); #1;
    rst = 1'b0;
    res_tag.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus_if.a = '0; bus_if.d = '0; bus_if.we = 1'b0; bus_if.rd = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++; if (bus_if.ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b required 0", bus_if.ready); end
    n_cmp++; if (bus_if.spo !== 32'h0) begin n_bad++; $display("FAIL reset_spo: got %h required 0", bus_if.spo); end
    n_cmp++; if (bus_if.mem_rd !== 1'b0) begin n_bad++; $display("FAIL reset_mem_rd: got %b required 0", bus_if.mem_rd); end
    n_cmp++; if (bus_if.mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %b required 0", bus_if.mem_we); end
    n_cmp++; if (bus_if.mem_a !== 32'h0) begin n_bad++; $display("FAIL reset_mem_a: got %h required 0", bus_if.mem_a); end
    n_cmp++; if (bus_if.mem_d !== 32'h0) begin n_bad++; $display("FAIL reset_mem_d: got %h required 0", bus_if.mem_d); end
    @(posedge clk); #1;
    rst = 1'b0;
    res_tag.delete();
  endtask

  task automatic test_fill_and_hit();
    logic [31:0] got; int lat, t0;
    bus_delay = 0;
    clear_log();
    cpu_req(1'b0, 32'h2000_0010, 32'h0, got, lat, t0);
    res_tag[idx_of(32'h2000_0010)] = tag_of(32'h2000_0010);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL fill_latency: got %0d required 5", lat); end
    n_cmp++; if (got !== 32'h85A5A5B5) begin n_bad++; $display("FAIL fill_spo: got %h required 85a5a5b5", got); end
    exp_q = '{32'h2000_0010, 32'h2000_0014, 32'h2000_0018, 32'h2000_001C};
    n_cmp++; if (rd_addr_q.size() != 4) begin n_bad++; $display("FAIL fill_pulses: got %0d required 4", rd_addr_q.size()); end
    for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) begin
      n_cmp++;
      if (rd_addr_q[i] !== exp_q[i] || rd_cyc_q[i] != t0 + 1 + i) begin
        n_bad++;
        $display("FAIL fill_word%0d: got a=%h cyc=%0d required a=%h cyc=%0d",
                 i, rd_addr_q[i], rd_cyc_q[i], exp_q[i], t0 + 1 + i);
      end
    end
    @(negedge clk); #1;
    n_cmp++; if (bus_if.ready !== 1'b0) begin n_bad++; $display("FAIL ready_one_cycle: got %b required 0", bus_if.ready); end
    clear_log();
    cpu_req(1'b0, 32'h2000_0018, 32'h0, got, lat, t0);
    n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL hit_latency: got %0d required 0", lat); end
    n_cmp++; if (got !== 32'h85A5A5BD) begin n_bad++; $display("FAIL hit_spo: got %h required 85a5a5bd", got); end
    n_cmp++; if (rd_addr_q.size() != 0) begin n_bad++; $display("FAIL hit_no_bus: got %0d pulses required 0", rd_addr_q.size()); end
  endtask

  task automatic test_write();
    logic [31:0] got; int lat, t0;
    bus_delay = 0;
    clear_log();
    cpu_req(1'b1, 32'h2000_0014, 32'hDEAD_BEEF, got, lat, t0);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wr_latency: got %0d required 2", lat); end
    n_cmp++; if (got !== 32'h0) begin n_bad++; $display("FAIL wr_spo: got %h required 0", got); end
    n_cmp++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h2000_0014 || wr_data_q[0] !== 32'hDEAD_BEEF || wr_cyc_q[0] != t0 + 1) begin
      n_bad++;
      $display("FAIL wr_bus: got %0d pulses a=%h d=%h required 1 pulse a=20000014 d=deadbeef at T+1",
               wr_addr_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'h0,
               (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0);
    end
    cpu_req(1'b0, 32'h2000_0014, 32'h0, got, lat, t0);
    n_cmp++; if (lat !== 0 || got !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_hit_read: got lat=%0d spo=%h required lat=0 spo=deadbeef", lat, got); end
    clear_log();
    cpu_req(1'b1, 32'h2000_1000, 32'h1234_5678, got, lat, t0);
    n_cmp++; if (lat !== 2 || wr_addr_q.size() != 1) begin n_bad++; $display("FAIL wr_miss: got lat=%0d pulses=%0d required lat=2 pulses=1", lat, wr_addr_q.size()); end
    clear_log();
    cpu_req(1'b0, 32'h2000_1000, 32'h0, got, lat, t0);
    res_tag[idx_of(32'h2000_1000)] = tag_of(32'h2000_1000);
    n_cmp++;
    if (lat !== 5 || got !== 32'h1234_5678 || rd_addr_q.size() != 4) begin
      n_bad++;
      $display("FAIL no_allocate: got lat=%0d spo=%h pulses=%0d required lat=5 spo=12345678 pulses=4",
               lat, got, rd_addr_q.size());
    end
  endtask

  task automatic test_bypass();
    logic [31:0] got; int lat, t0;
    bus_delay = 3;
    for (int k = 0; k < 2; k++) begin
      clear_log();
      cpu_req(1'b0, 32'hF000_0004, 32'h0, got, lat, t0);
      n_cmp++;
      if (lat !== 5 || got !== 32'h55A5A5A1 || rd_addr_q.size() != 1 || (rd_addr_q.size() == 1 && rd_addr_q[0] !== 32'hF000_0004)) begin
        n_bad++;
        $display("FAIL bypass%0d: got lat=%0d spo=%h pulses=%0d required lat=5 spo=55a5a5a1 pulses=1 at f0000004",
                 k, lat, got, rd_addr_q.size());
      end
    end
  endtask

  task automatic test_conflict();
    logic [31:0] got; int lat, t0, e;
    logic [31:0] a0, a1;
    bus_delay = 0;
    a0 = 32'h2000_0010;
    a1 = a0 + LINES * 16;
    e = exp_lat(1'b0, a0, 0);
    cpu_req(1'b0, a0, 32'h0, got, lat, t0);
    res_tag[idx_of(a0)] = tag_of(a0);
    n_cmp++; if (lat !== e || got !== mem_val(a0)) begin n_bad++; $display("FAIL conflict_first: got lat=%0d spo=%h required lat=%0d spo=%h", lat, got, e, mem_val(a0)); end
    clear_log();
    cpu_req(1'b0, a1, 32'h0, got, lat, t0);
    res_tag[idx_of(a1)] = tag_of(a1);
    n_cmp++; if (lat !== 5 || got !== mem_val(a1) || rd_addr_q.size() != 4) begin n_bad++; $display("FAIL conflict_evict: got lat=%0d spo=%h pulses=%0d required lat=5 spo=%h pulses=4", lat, got, rd_addr_q.size(), mem_val(a1)); end
    clear_log();
    cpu_req(1'b0, a0, 32'h0, got, lat, t0);
    res_tag[idx_of(a0)] = tag_of(a0);
    n_cmp++; if (lat !== 5 || got !== mem_val(a0) || rd_addr_q.size() != 4) begin n_bad++; $display("FAIL conflict_reread: got lat=%0d spo=%h pulses=%0d required lat=5 spo=%h pulses=4", lat, got, rd_addr_q.size(), mem_val(a0)); end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] got; int lat, t0, k, readies;
    bus_delay = 2;
    clear_log();
    @(negedge clk);
    bus_if.a = 32'h2000_0020; bus_if.rd = 1'b1;
    @(posedge clk); #1;
    bus_if.rd = 1'b0;
    k = 0;
    while (rd_addr_q.size() < 3 && k < 100) begin @(negedge clk); #1; k++; end
    n_cmp++; if (rd_addr_q.size() != 3) begin n_bad++; $display("FAIL abort_reach_word2: got %0d pulses required 3", rd_addr_q.size()); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus_if.mem_rd !== 1'b0 || bus_if.ready !== 1'b0) begin n_bad++; $display("FAIL abort_outputs: got mem_rd=%b ready=%b required 0 0", bus_if.mem_rd, bus_if.ready); end
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b0;
    res_tag.delete();
    readies = 0;
    repeat (6) begin @(negedge clk); #1; if (bus_if.ready) readies++; end
    n_cmp++; if (readies != 0 || rd_addr_q.size() != 3) begin n_bad++; $display("FAIL abort_quiet: got readies=%0d pulses=%0d required 0 and 3", readies, rd_addr_q.size()); end
    clear_log();
    cpu_req(1'b0, 32'h2000_0020, 32'h0, got, lat, t0);
    res_tag[idx_of(32'h2000_0020)] = tag_of(32'h2000_0020);
    exp_q = '{32'h2000_0020, 32'h2000_0024, 32'h2000_0028, 32'h2000_002C};
    n_cmp++; if (lat !== 13 || got !== mem_val(32'h2000_0020)) begin n_bad++; $display("FAIL abort_refill: got lat=%0d spo=%h required lat=13 spo=%h", lat, got, mem_val(32'h2000_0020)); end
    n_cmp++; if (rd_addr_q.size() != 4) begin n_bad++; $display("FAIL abort_refill_pulses: got %0d required 4", rd_addr_q.size()); end
    for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) begin
      n_cmp++; if (rd_addr_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL abort_refill_word%0d: got %h required %h", i, rd_addr_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, addr, wd; int lat, t0, k;
    bus_delay = 0;
    cpu_req(1'b0, 32'h2000_0030, 32'h0, got, lat, t0);
    res_tag[idx_of(32'h2000_0030)] = tag_of(32'h2000_0030);
    clear_log();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      addr = 32'h2000_0030 + 4 * $urandom_range(0, 3) + $urandom_range(0, 3);
      bus_if.a = addr; bus_if.rd = 1'b1;
      #1;
      n_cmp++; if (bus_if.ready !== 1'b1 || bus_if.spo !== mem_val(addr)) begin n_bad++; $display("FAIL b2b_hit%0d: got ready=%b spo=%h required 1 %h", i, bus_if.ready, bus_if.spo, mem_val(addr)); end
      @(negedge clk);
    end
    wd = $urandom;
    bus_if.a = 32'h2000_0034; bus_if.d = wd; bus_if.we = 1'b1;
    #1;
    n_cmp++; if (bus_if.ready !== 1'b0) begin n_bad++; $display("FAIL write_priority: got ready=%b required 0", bus_if.ready); end
    @(posedge clk); #1;
    bus_if.we = 1'b0; bus_if.rd = 1'b0;
    k = 0;
    while (!bus_if.ready && k < 20) begin @(negedge clk); #1; k++; end
    n_cmp++; if (k != 2 || rd_addr_q.size() != 0 || wr_addr_q.size() != 1) begin n_bad++; $display("FAIL write_priority_done: got cycles=%0d rd=%0d wr=%0d required 2 0 1", k, rd_addr_q.size(), wr_addr_q.size()); end
    cpu_req(1'b0, 32'h2000_0034, 32'h0, got, lat, t0);
    n_cmp++; if (lat !== 0 || got !== wd) begin n_bad++; $display("FAIL write_hit_update: got lat=%0d spo=%h required 0 %h", lat, got, wd); end
  endtask

  task automatic test_random();
    logic [31:0] got, addr, wd, exp_d; int lat, t0, e, e_rd;
    bit wr;
    for (int n = 0; n < 60; n++) begin
      bus_delay = $urandom_range(0, 2);
      wr = ($urandom_range(0, 3) == 0);
      wd = $urandom;
      if ($urandom_range(0, 4) == 0)
        addr = 32'hF000_0000 + 4 * $urandom_range(0, 7);
      else
        addr = 32'h2000_0000 + LINES * 16 * $urandom_range(0, 1) + 16 * $urandom_range(0, 3) + 4 * $urandom_range(0, 3);
      addr = addr + $urandom_range(0, 3);
      e     = exp_lat(wr, addr, bus_delay);
      e_rd  = wr ? 0 : (!is_cached(addr) ? 1 : (model_hit(addr) ? 0 : 4));
      exp_d = wr ? 32'h0 : mem_val(addr);
      clear_log();
      cpu_req(wr, addr, wd, got, lat, t0);
      if (!wr && is_cached(addr)) res_tag[idx_of(addr)] = tag_of(addr);
      n_cmp++;
      if (lat !== e || got !== exp_d || rd_addr_q.size() != e_rd || wr_addr_q.size() != int'(wr)) begin
        n_bad++;
        $display("FAIL random%0d: a=%h wr=%b got lat=%0d spo=%h rd=%0d wr=%0d required lat=%0d spo=%h rd=%0d wr=%0d",
                 n, addr, wr, lat, got, rd_addr_q.size(), wr_addr_q.size(), e, exp_d, e_rd, int'(wr));
      end
      if (wr && wr_addr_q.size() == 1) begin
        n_cmp++;
        if (wr_addr_q[0] !== {addr[31:2], 2'b00} || wr_data_q[0] !== wd) begin
          n_bad++;
          $display("FAIL random%0d_wdata: got a=%h d=%h required a=%h d=%h", n, wr_addr_q[0], wr_data_q[0], {addr[31:2], 2'b00}, wd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_and_hit();
    test_write();
    test_bypass();
    test_conflict();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    hold_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/l1_cache.md
# l1_cache

Direct-mapped, write-through, no-write-allocate cache between the pCPU multicycle core's memory port and the system bus. It speaks the core's one-cycle-pulse request / `ready` protocol on both sides. Cacheable reads hit in zero wait cycles; misses refill a 4-word line. Uncacheable traffic (boot ROM, MMIO) and all writes pass straight through to the bus.

## Interface
- `LINES`, 256: number of cache lines, power of two; index width `IW = log2(LINES)`.
- `CACHED_HI`, 4'h2: a request is cacheable iff `a[31:28] == CACHED_HI`.
- `clk` in 1: clock. One clock; all state updates on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `a` in 32: CPU address; `a[1:0]` ignored.
- `d` in 32: CPU write word, stored and forwarded unmodified.
- `we` in 1: CPU write request, one-cycle pulse.
- `rd` in 1: CPU read request, one-cycle pulse.
- `spo` out 32: read data to CPU, valid when `ready`=1.
- `ready` out 1: completion strobe to CPU.
- `mem_a` out 32: bus address, word-aligned (`[1:0]`=0).
- `mem_d` out 32: bus write data.
- `mem_we` out 1: bus write pulse.
- `mem_rd` out 1: bus read pulse.
- `mem_spo` in 32: bus read data, valid when `mem_ready`=1.
- `mem_ready` in 1: bus completion strobe.

## Operation
- Address split: offset `a[3:2]`, index `a[IW+3:4]`, tag `a[31:IW+4]`. Storage: `LINES`×4 data words, `LINES` tags, `LINES` valid bits in a flop vector.
- States: IDLE, FILL_REQ, FILL_WAIT, BYP_REQ, BYP_WAIT, WR_REQ, WR_WAIT, RESP.
- IDLE, `we`=1 (priority over `rd`):
  - Latch `a` and `d`.
  - If cacheable and hit, write `d` into the data word at the same edge.
  - Go to WR_REQ. Writes never allocate.
- IDLE, `rd`=1, cacheable, hit (valid and tag match): `ready`=1 and `spo`=the word, combinationally in the same cycle. Stay in IDLE.
- IDLE, `rd`=1, cacheable, miss: latch address, clear word counter `cnt`=0, go to FILL_REQ.
- IDLE, `rd`=1, uncacheable: latch address, go to BYP_REQ.
- FILL_REQ:
  - Drive `mem_rd`=1 and `mem_a`={line base, `cnt`, 2'b0}.
  - If `mem_ready`, store `mem_spo` into word `cnt` and advance; otherwise go to FILL_WAIT.
- FILL_WAIT: hold `mem_a`, `mem_rd`=0. On `mem_ready`, store the word and advance.
- Advance: if `cnt`==3, write tag, set valid, and go to RESP. Otherwise `cnt`+1 and go to FILL_REQ.
- BYP_REQ / BYP_WAIT:
  - Same pulse/wait pattern, single word, `mem_a`={latched[31:2],2'b0}.
  - Capture `mem_spo` into the response register, then go to RESP. No cache state changes.
- WR_REQ / WR_WAIT: same pattern with `mem_we`=1 for one cycle and `mem_d`=latched data. On `mem_ready`, go to RESP.
- RESP:
  - `ready`=1 for exactly one cycle, then IDLE.
  - `spo`: the requested word for a fill (read from the array), the captured word for bypass, 0 for writes.
- `rd`/`we` arriving outside IDLE are ignored.
- `ready` is 0 in all states except RESP and an IDLE hit. In particular it is 0 on any IDLE cycle without a hit read, including the request cycle of a miss, bypass or write.
- `mem_rd` and `mem_we` are never both 1.

## Timing
- Reset: state IDLE, all valid bits 0, `cnt`=0. `ready`, `mem_rd`, `mem_we` = 0; `spo`, `mem_a`, `mem_d` = 0.
- Reset asserted mid-transaction aborts it. There is no partial-line validity: valid is set only on the final fill word.
- Request at cycle T. Latencies with a zero-wait bus (`mem_ready` in the pulse cycle):
  - hit: `ready` at T.
  - miss: `mem_rd` at T+1..T+4, `ready` at T+5.
  - bypass read or write: `mem_*` pulse at T+1, `ready` at T+2.
- Each bus wait cycle adds one cycle per word.
- Bus `mem_ready` is accepted in the REQ cycle or any following WAIT cycle.

## Test plan
- Reset, then read 0x2000_0010 with `mem_ready` tied 1 (bus returns addr^0xA5A5A5A5) -> `mem_rd` at 0x2000_0010/14/18/1C on T+1..T+4; `ready` at T+5 with `spo`=0x85A5A5B5. Re-read 0x2000_0018 -> `ready` same cycle, `spo`=0x85A5A5BD, no `mem_rd`.
- Write 0xDEADBEEF to 0x2000_0014 (line resident) -> `mem_we` at T+1 with that address/data, `ready` at T+2. Then read 0x2000_0014 -> hit, `spo`=0xDEADBEEF.
- Write to non-resident 0x2000_1000, then read it -> write goes through; the read misses and refills (no allocate).
- Read 0xF000_0004 twice with bus `mem_ready` delayed 3 cycles -> both go through to the bus, `ready` at T+5 each time, never cached.
- Conflict: read 0x2000_0010, then 0x2000_0010+(LINES·16) -> second read refills and evicts; re-read of the first address misses again.
- Assert `rst` during FILL_WAIT of word 2 -> IDLE next cycle, `mem_rd`=0, no `ready`; re-read of the same address performs a full 4-word refill.
